// File: rtl/mem_arb_pkg.sv
// Shared definitions for the shared data memory arbiter: command codes and a log2 helper.
package mem_arb_pkg;

    localparam int W_MEM_CMD = 3;

    typedef enum logic [W_MEM_CMD-1:0] {
        MEM_NONE  = 3'd0,
        MEM_READ  = 3'd1,
        MEM_WRITE = 3'd2,
        MEM_LL    = 3'd3,
        MEM_SC    = 3'd4
    } mem_cmd_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the winner.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? clog2(N) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_idx;
    logic          any_gnt;

    // Scan starts at rr_ptr and wraps; first requester wins.
    always_comb begin
        int q;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        q       = 0;
        for (int i = 0; i < N; i++) begin
            q = int'(rr_ptr) + i;
            if (q >= N) q = q - N;
            if (!any_gnt && req[q]) begin
                any_gnt = 1'b1;
                gnt[q]  = 1'b1;
                gnt_idx = PW'(q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (any_gnt)
            rr_ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end

endmodule

// File: rtl/shared_data_memory_arb.sv
// N-port shared data memory with round-robin arbitration, byte-enabled writes and registered reads.
// Define ATOMIC_RESV_EN to give LL/SC real per-port reservations.
module shared_data_memory_arb
    import mem_arb_pkg::*;
#(
    parameter int N_PORTS     = 2,
    parameter int W_DATA      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int W_ADDR      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS*W_MEM_CMD-1:0]  mem_cmd,
    input  logic [N_PORTS*W_ADDR-1:0]     addr,
    input  logic [N_PORTS*W_DATA-1:0]     wdata,
    input  logic [N_PORTS*(W_DATA/8)-1:0] be,
    output logic [N_PORTS-1:0]            gnt,
    output logic [N_PORTS-1:0]            rvalid,
    output logic [N_PORTS*W_DATA-1:0]     rdata,
    output logic [N_PORTS-1:0]            err,
    output logic [N_PORTS-1:0]            sc_ok
);

    localparam int AW = clog2(DEPTH_WORDS);
    localparam int NB = W_DATA / 8;
    localparam int PW = (N_PORTS > 1) ? clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0][W_MEM_CMD-1:0] cmd_a;
    logic [N_PORTS-1:0][W_ADDR-1:0]    addr_a;
    logic [N_PORTS-1:0][W_DATA-1:0]    wdata_a;
    logic [N_PORTS-1:0][NB-1:0]        be_a;

    assign cmd_a   = mem_cmd;
    assign addr_a  = addr;
    assign wdata_a = wdata;
    assign be_a    = be;

    logic [N_PORTS-1:0] req;

    // Codes above MEM_SC are idle; reset masks every request so nothing is granted.
    always_comb begin
        req = '0;
        for (int p = 0; p < N_PORTS; p++)
            req[p] = !rst && (cmd_a[p] != MEM_NONE) && (cmd_a[p] <= MEM_SC);
    end

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    logic                 g_any;
    logic [PW-1:0]        g_idx;
    logic [W_MEM_CMD-1:0] s_cmd;
    logic [W_ADDR-1:0]    s_addr;
    logic [W_DATA-1:0]    s_wdata;
    logic [NB-1:0]        s_be;
    logic [AW-1:0]        widx;
    logic                 bad, is_rd, is_wr, is_sc, sc_pass, commit;

    always_comb begin
        g_idx = '0;
        for (int p = 0; p < N_PORTS; p++)
            if (gnt[p]) g_idx = PW'(p);
    end

    assign g_any   = |gnt;
    assign s_cmd   = cmd_a[g_idx];
    assign s_addr  = addr_a[g_idx];
    assign s_wdata = wdata_a[g_idx];
    assign s_be    = be_a[g_idx];
    assign widx    = s_addr[AW+1:2];
    assign bad     = (s_addr[1:0] != 2'b00) || ((s_addr >> (AW + 2)) != '0);
    assign is_rd   = (s_cmd == MEM_READ) || (s_cmd == MEM_LL);
    assign is_wr   = (s_cmd == MEM_WRITE);
    assign is_sc   = (s_cmd == MEM_SC);
    assign commit  = g_any && !bad && (is_wr || (is_sc && sc_pass));

`ifdef ATOMIC_RESV_EN
    logic [N_PORTS-1:0]         resv_v;
    logic [N_PORTS-1:0][AW-1:0] resv_idx;

    assign sc_pass = resv_v[g_idx] && (resv_idx[g_idx] == widx);

    // Any store landing on a reserved word kills that reservation, including the SC's own.
    always_ff @(posedge clk) begin
        if (rst) begin
            resv_v <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++)
                if (commit && resv_idx[p] == widx) resv_v[p] <= 1'b0;
            if (g_any && !bad && s_cmd == MEM_LL) begin
                resv_v[g_idx]   <= 1'b1;
                resv_idx[g_idx] <= widx;
            end
            if (g_any && is_sc) resv_v[g_idx] <= 1'b0;
        end
    end
`else
    assign sc_pass = 1'b1;
`endif

    logic [W_DATA-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (commit)
            for (int b = 0; b < NB; b++)
                if (s_be[b]) mem[widx][b*8 +: 8] <= s_wdata[b*8 +: 8];
    end

    logic [N_PORTS-1:0]             rvalid_q, err_q, sc_ok_q;
    logic [N_PORTS-1:0][W_DATA-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            err_q    <= '0;
            sc_ok_q  <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            err_q    <= '0;
            sc_ok_q  <= '0;
            if (g_any) begin
                rvalid_q[g_idx] <= is_rd || is_sc;
                err_q[g_idx]    <= bad;
                sc_ok_q[g_idx]  <= is_sc && !bad && sc_pass;
                if (bad)
                    rdata_q[g_idx] <= '0;
                else if (is_rd)
                    rdata_q[g_idx] <= mem[widx];
            end
        end
    end

    // Masking with rst drops a response whose grant landed just before reset.
    assign rvalid = rst ? '0 : rvalid_q;
    assign err    = rst ? '0 : err_q;
    assign sc_ok  = rst ? '0 : sc_ok_q;
    assign rdata  = rst ? '0 : rdata_q;

endmodule

// File: doc/shared_data_memory_arb.md
Name: shared_data_memory_arb

Overview:
N-port shared data memory for the multi-core processor; successor to the fixed two-port data memory. Arbitrates one access per cycle among N_PORTS cores with a round-robin arbiter and a per-port grant handshake. Supports byte-enabled writes and registered reads. Flags bad addresses with a per-port error pulse instead of halting simulation. Sits between each core's MEM stage and the data-memory array.

Parameters:
N_PORTS, 2, number of requesting cores (>=1)
W_DATA, 32, word width; must be a multiple of 8
DEPTH_WORDS, 4096, words of storage; power of two; AW = log2(DEPTH_WORDS)
W_ADDR, 32, byte-address width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
mem_cmd  in  N_PORTS*W_MEM_CMD  per-port command; port p occupies slice [p*W_MEM_CMD +: W_MEM_CMD]
addr  in  N_PORTS*W_ADDR  per-port byte address
wdata  in  N_PORTS*W_DATA  per-port write data
be  in  N_PORTS*(W_DATA/8)  per-port byte enables; used by WRITE and SC
gnt  out  N_PORTS  combinational one-hot grant this cycle
rvalid  out  N_PORTS  read/LL/SC response valid; one-cycle pulse
rdata  out  N_PORTS*W_DATA  registered read data
err  out  N_PORTS  bad-address pulse, aligned with rvalid timing
sc_ok  out  N_PORTS  SC result; valid when rvalid is high

Behaviour:
- Commands: MEM_NONE=0, MEM_READ=1, MEM_WRITE=2, MEM_LL=3, MEM_SC=4; W_MEM_CMD=3. Codes 5-7 are treated as NONE.
- Arbitration:
  - rr_ptr resets to 0. Each cycle, scan ports rr_ptr, rr_ptr+1, ... mod N_PORTS.
  - Grant the first port with a non-NONE command. gnt is combinational in the same cycle.
  - On any grant, rr_ptr <= (granted+1) mod N_PORTS at posedge. With no grant, rr_ptr holds.
  - A requester holds cmd/addr/wdata/be stable until it sees gnt. A waiting port is granted within N_PORTS cycles.
- Address decode: word index = addr[AW+1:2].
  - Bad address means addr[1:0]!=0 or addr[W_ADDR-1:AW+2]!=0.
  - A bad-address access is still granted. Memory is not modified.
  - The next cycle, err=1 and rdata=0. rvalid=1 for READ/LL/SC; rvalid stays 0 for WRITE.
- WRITE: at the posedge of the grant cycle, byte lane i is written iff be[i]. be=0 writes nothing. No response pulse.
- READ: rvalid=1 the cycle after grant. rdata = word contents as of the grant cycle. rdata holds until that port's next response. Read latency is exactly 1 cycle.
- Only one array access per cycle, so there are no read/write collisions. Memory contents are not reset.
- Reset (rst high at a posedge):
  - rvalid, err, sc_ok and every rdata slice clear to 0. rr_ptr clears to 0. Reservations are cleared.
  - gnt is forced to 0 while rst is high, so a command presented during reset is never granted and never writes.
  - A grant from the cycle before reset asserts is discarded: no rvalid follows.

Optional Feature:
Macro ATOMIC_RESV_EN.
- Defined:
  - Each port has a reservation {valid, word_index}.
  - A granted LL behaves as READ and sets that port's reservation.
  - A granted SC writes (with be) only if its reservation is valid and matches the word. It responds with rvalid=1 and sc_ok equal to success, and always clears its own reservation.
  - Any committed WRITE or successful SC to word w clears every port's reservation on w.
  - A bad-address LL/SC sets no reservation; SC returns sc_ok=0.
- Undefined: LL behaves exactly as READ. SC behaves as WRITE, plus rvalid=1 with sc_ok=1. There is no reservation state.

Decomposition:
- Package mem_arb_pkg: MEM_* command codes, W_MEM_CMD, and a log2 helper function.
- Sub-module rr_arbiter (parameter N): request vector in, one-hot grant out, owns rr_ptr. Reusable by the instruction-fetch path.

Test Plan:
- Reset sequence: hold rst 2 cycles with port0 WRITE @0x10 present -> gnt=0; a later READ @0x10 returns the pre-test value; all outputs 0 during reset.
- Byte enables: WRITE 0xAABBCCDD @0x20 be=4'hF, then WRITE 0x11223344 be=4'b0101 -> READ @0x20 returns 0xAA22CC44 one cycle after gnt.
- Contention: N_PORTS=2, both READ continuously -> gnt alternates 01,10,01,...; each rvalid follows its gnt by exactly 1 cycle.
- Bad address: READ @0x0000_4000 -> err=1, rvalid=1, rdata=0 next cycle. WRITE @0x22 -> err=1, memory unchanged.
- Reservation (ATOMIC_RESV_EN): port0 LL @0x40, port1 WRITE @0x40, port0 SC @0x40 -> sc_ok=0, word keeps port1 data. Repeating without the intervening write -> sc_ok=1 and the word is updated.
- Fairness: N_PORTS=4, ports 1-3 requesting continuously -> port1 waits at most 4 cycles; grant order 1,2,3,1,...
